// File: rtl/sgpr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgpr_arb_pkg
//  Purpose  : Shared types and default sizing for the SGPR write arbiter.
//             Holds the controller state encoding and the default port count,
//             address width and data width used by sgpr_wr_arbiter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sgpr_arb_pkg;

    localparam int SGPR_ARB_NUM_PORTS = 8;
    localparam int SGPR_ARB_ADDR_W    = 9;
    localparam int SGPR_ARB_DATA_W    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

endpackage : sgpr_arb_pkg
`default_nettype wire

// File: rtl/sgpr_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sgpr_rr_pick
//  Purpose  : Combinational NUM_PORTS-way round-robin picker. Searches the
//             request vector starting one past the last granted port and
//             wrapping at NUM_PORTS-1 back to 0.
//  Ports    : req_i        - request vector, one bit per port
//             last_grant_i - index of the most recently granted port
//             grant_o      - one-hot grant (all zero when no request)
//             grant_idx_o  - binary index of the granted port
//             any_o        - high when at least one request is present
//  Revision : 1.0 - initial release
// ============================================================================
module sgpr_rr_pick #(
    parameter int NUM_PORTS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] cand;

    // Offsets 1..NUM_PORTS visit every port exactly once, the last granted
    // port being considered last; the first requesting candidate wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((int'(last_grant_i) + off) % NUM_PORTS);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule : sgpr_rr_pick
`default_nettype wire

// File: rtl/sgpr_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sgpr_wr_arbiter
//  Purpose  : Round-robin arbiter serialising SGPR write requests from
//             NUM_PORTS requesters (simd0-3, simf0-3) into a single register
//             file write port.
//             Build option SGPR_WR_ARB_MASK_MERGE_EN:
//               defined   - IDLE -> READ -> WRITE read-modify-write; the
//                           old word is read and merged under the bit mask.
//               undefined - IDLE -> WRITE; captured data written as-is,
//                           mask ignored, no register file read.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_valid/addr/data/mask - per-port write requests (flattened)
//             req_ready           - one-hot accept pulse (IDLE only)
//             rd_en/rd_addr       - old-data read strobe and address
//             rd_data             - read data, valid the cycle after rd_en
//             wr_en/wr_addr/wr_data - register file write
//             done_valid/done_port - write-complete pulse and port index
//             busy                - high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module sgpr_wr_arbiter
    import sgpr_arb_pkg::*;
#(
    parameter int NUM_PORTS = SGPR_ARB_NUM_PORTS,
    parameter int ADDR_W    = SGPR_ARB_ADDR_W,
    parameter int DATA_W    = SGPR_ARB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data,
    input  logic [NUM_PORTS*DATA_W-1:0] req_mask,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [DATA_W-1:0]           rd_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        done_valid,
    output logic [2:0]                  done_port,
    output logic                        busy
);

    localparam int               IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // Reset value makes port 0 the first winner.
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_PORTS - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  last_q,  last_d;
    logic [IDX_W-1:0]  port_q,  port_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    logic [NUM_PORTS-1:0] w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;

    logic [ADDR_W-1:0] w_addr_arr [NUM_PORTS];
    logic [DATA_W-1:0] w_data_arr [NUM_PORTS];

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
            assign w_addr_arr[p] = req_addr[p*ADDR_W +: ADDR_W];
            assign w_data_arr[p] = req_data[p*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef SGPR_WR_ARB_MASK_MERGE_EN
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] w_mask_arr [NUM_PORTS];

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack_mask
            assign w_mask_arr[p] = req_mask[p*DATA_W +: DATA_W];
        end
    endgenerate
`else
    // Mask and read data have no consumer when merging is compiled out.
    logic w_unused_merge;
    assign w_unused_merge = ^{req_mask, rd_data};
`endif

    sgpr_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (w_grant),
        .grant_idx_o  (w_idx),
        .any_o        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= C_LAST_RST;
            port_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // All outputs are forced low while rst is high so that a transaction
    // caught mid-flight by reset produces no write or completion.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        port_d     = port_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
        mask_d     = mask_q;
`endif
        req_ready  = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        done_valid = 1'b0;
        done_port  = '0;
        busy       = 1'b0;

        if (!rst) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        req_ready = w_grant;
                        last_d    = w_idx;
                        port_d    = w_idx;
                        addr_d    = w_addr_arr[w_idx];
                        data_d    = w_data_arr[w_idx];
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
                        mask_d    = w_mask_arr[w_idx];
                        state_d   = ST_READ;
`else
                        state_d   = ST_WRITE;
`endif
                    end
                end
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
                ST_READ: begin
                    rd_en   = 1'b1;
                    rd_addr = addr_q;
                    state_d = ST_WRITE;
                end
`endif
                ST_WRITE: begin
                    wr_en      = 1'b1;
                    wr_addr    = addr_q;
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
                    // rd_data holds the old word for the read issued last cycle.
                    wr_data    = (data_q & mask_q) | (rd_data & ~mask_q);
`else
                    wr_data    = data_q;
`endif
                    done_valid = 1'b1;
                    done_port  = 3'(port_q);
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule : sgpr_wr_arbiter
`default_nettype wire

// File: tb/tb_sgpr_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sgpr_wr_arbiter
//  Purpose  : Self-checking bench for sgpr_wr_arbiter. Expected grants and
//             writes are queued as requests are issued and checked when the
//             arbiter produces them. Adapts its latency expectations to the
//             SGPR_WR_ARB_MASK_MERGE_EN build option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sgpr_wr_arbiter;

    localparam int NP = 8;
    localparam int AW = 9;
    localparam int DW = 64;
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int P = LAT + 1;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    req_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic [NP*DW-1:0] req_mask;
    logic [NP-1:0]    req_ready;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             done_valid;
    logic [2:0]       done_port;
    logic             busy;

    sgpr_wr_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_ready  (req_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done_valid (done_valid),
        .done_port  (done_port),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            port;
    } wr_t;

    int      exp_grant [$];
    wr_t     exp_wr    [$];
    int      pend_rd   [$];
    int      pend_wr   [$];
    int      gcyc      [$];
    int      n_cmp    = 0;
    int      n_err    = 0;
    int      cyc      = 0;
    int      last_acc = -100;
    logic [NP-1:0] oneshot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] merged(input logic [DW-1:0] d, input logic [DW-1:0] m,
                                             input logic [DW-1:0] old);
`ifdef SGPR_WR_ARB_MASK_MERGE_EN
        return (d & m) | (old & ~m);
`else
        return d;
`endif
    endfunction

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic one);
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
        req_mask[p*DW +: DW] = m;
        oneshot[p]           = one;
        req_valid[p]         = 1'b1;
    endtask

    task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [DW-1:0] m);
        wr_t e;
        e.addr = a;
        e.data = merged(d, m, rd_data);
        e.port = p;
        exp_grant.push_back(p);
        exp_wr.push_back(e);
    endtask

    // One clock: sample at the falling edge, return just after the rising
    // edge so the caller drives the next cycle's inputs.
    task automatic tick();
        int   idx;
        logic exp_busy;
        wr_t  e;
        idx = -1;
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("rst_ctl", 64'({req_ready, rd_en, wr_en, done_valid, busy, done_port}), 64'd0);
            chk("rst_bus", 64'(rd_addr) | 64'(wr_addr) | wr_data, 64'd0);
        end else begin
            exp_busy = (cyc > last_acc) && (cyc <= last_acc + LAT);
            chk("busy", 64'(busy), 64'(exp_busy));
            if (req_ready != '0) begin
                for (int i = 0; i < NP; i++) if (req_ready[i]) idx = i;
                chk("ready_legal", 64'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 64'd1);
                chk("accept_spacing", 64'((cyc - last_acc) >= P), 64'd1);
                if (exp_grant.size() == 0) chk("grant_unexpected", 64'(idx), 64'hFF);
                else                       chk("grant_port", 64'(idx), 64'(exp_grant.pop_front()));
                gcyc.push_back(cyc);
                last_acc = cyc;
                if (LAT == 2) pend_rd.push_back(cyc + 1);
                pend_wr.push_back(cyc + LAT);
            end
            if (rd_en) begin
                if (pend_rd.size() == 0) chk("rd_en_spurious", 64'd1, 64'd0);
                else begin
                    chk("rd_cycle", 64'(cyc), 64'(pend_rd.pop_front()));
                    chk("rd_addr", 64'(rd_addr), (exp_wr.size() != 0) ? 64'(exp_wr[0].addr) : 64'd0);
                end
            end else begin
                chk("rd_addr_idle", 64'(rd_addr), 64'd0);
                if (pend_rd.size() != 0 && pend_rd[0] == cyc) begin
                    chk("rd_en_missing", 64'd0, 64'd1);
                    void'(pend_rd.pop_front());
                end
            end
            if (wr_en) begin
                chk("done_valid", 64'(done_valid), 64'd1);
                if (pend_wr.size() == 0 || exp_wr.size() == 0) chk("wr_spurious", 64'd1, 64'd0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(pend_wr.pop_front()));
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", wr_data, e.data);
                    chk("done_port", 64'(done_port), 64'(e.port));
                end
            end else begin
                chk("wr_idle", 64'(wr_addr) | wr_data | 64'({done_valid, done_port}), 64'd0);
                if (pend_wr.size() != 0 && pend_wr[0] == cyc) begin
                    chk("wr_missing", 64'd0, 64'd1);
                    void'(pend_wr.pop_front());
                    if (exp_wr.size() != 0) void'(exp_wr.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (idx >= 0 && oneshot[idx]) req_valid[idx] = 1'b0;
    endtask

    task automatic wait_grants();
        for (int k = 0; k < 100; k++) begin
            if (exp_grant.size() == 0) break;
            tick();
        end
        if (exp_grant.size() != 0) begin
            chk("grant_timeout", 64'(exp_grant.size()), 64'd0);
            exp_grant.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_mask  = '0;
        rd_data   = '0;
        oneshot   = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single request with partial mask
        rd_data = 64'h1234_5678_9ABC_DEF0;
        expect_txn(2, 9'h1A0, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_FFFF_FFFF);
        set_req(2, 9'h1A0, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_FFFF_FFFF, 1'b1);
        wait_grants();
        repeat (P + 1) tick();

        // All ports continuously valid from reset: 0..7 then 0 again
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        last_acc = -100;
        gcyc.delete();
        rd_data = 64'hCAFE_F00D_DEAD_BEEF;
        for (int i = 0; i < NP; i++)
            set_req(i, 9'(9'h040 + i), {8{8'(8'h11 * (i + 1))}}, 64'h00FF_00FF_00FF_00FF, 1'b0);
        for (int k = 0; k <= NP; k++)
            expect_txn(k % NP, 9'(9'h040 + (k % NP)), {8{8'(8'h11 * ((k % NP) + 1))}},
                       64'h00FF_00FF_00FF_00FF);
        wait_grants();
        req_valid = '0;
        repeat (P + 1) tick();
        for (int i = 1; i < gcyc.size(); i++)
            chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(P));

        // last_grant = 4, then ports 3 and 5 together: 5 first, then 3
        rd_data = 64'h0;
        expect_txn(4, 9'h004, 64'h4444, 64'hFFFF);
        set_req(4, 9'h004, 64'h4444, 64'hFFFF, 1'b1);
        wait_grants();
        expect_txn(5, 9'h005, 64'h5555, 64'hFFFF_FFFF);
        expect_txn(3, 9'h003, 64'h3333, 64'hFFFF_FFFF);
        set_req(5, 9'h005, 64'h5555, 64'hFFFF_FFFF, 1'b1);
        set_req(3, 9'h003, 64'h3333, 64'hFFFF_FFFF, 1'b1);
        wait_grants();
        repeat (P + 1) tick();

        // Reset right after accepting port 1: transaction abandoned
        expect_txn(1, 9'h011, 64'h1111, 64'hFF);
        set_req(1, 9'h011, 64'h1111, 64'hFF, 1'b1);
        wait_grants();
        rst = 1'b1;
        void'(exp_wr.pop_front());
        pend_rd.delete();
        pend_wr.delete();
        last_acc = -100;
        tick();
        rst = 1'b0;
        tick();
        rd_data = 64'h0F0F_0F0F_0F0F_0F0F;
        expect_txn(0, 9'h100, 64'h0000_0000_0000_00AA, 64'hFF);
        expect_txn(1, 9'h101, 64'h0000_0000_0000_BB00, 64'hFF00);
        set_req(0, 9'h100, 64'h0000_0000_0000_00AA, 64'hFF, 1'b1);
        set_req(1, 9'h101, 64'h0000_0000_0000_BB00, 64'hFF00, 1'b1);
        wait_grants();
        repeat (P + 1) tick();

        // All-zero mask still writes and completes
        rd_data = 64'h0BAD_0BAD_0BAD_0BAD;
        expect_txn(6, 9'h1C6, 64'hA5A5, 64'h0);
        set_req(6, 9'h1C6, 64'hA5A5, 64'h0, 1'b1);
        wait_grants();
        repeat (P + 1) tick();

        // Port 4 gives up while port 0 is serviced: never granted
        rd_data = 64'h0;
        expect_txn(0, 9'h0A0, 64'h7777, 64'hFFFF);
        set_req(0, 9'h0A0, 64'h7777, 64'hFFFF, 1'b1);
        set_req(4, 9'h0A4, 64'h9999, 64'hFFFF, 1'b1);
        wait_grants();
        repeat (LAT - 1) tick();
        req_valid[4] = 1'b0;
        repeat (3 * P) tick();

        chk("pending_grants", 64'(exp_grant.size()), 64'd0);
        chk("pending_writes", 64'(exp_wr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sgpr_wr_arbiter
`default_nettype wire
